// File: rtl/alu_serial.sv
// alu_serial: slice-serial ALU execute unit.
// Operands are consumed SLICE bits per cycle, LSB first, under a start/done
// handshake. The result, zero and illegal outputs only change on the edge
// that enters DONE, so downstream logic sees stable values between operations.
module alu_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] b_eff;
  logic [SLICE:0]   sum_ext;
  logic [SLICE-1:0] slice_res;
  logic             is_sub;
  logic             legal;
  logic             carry_msb_in;
  logic             ovf;
  logic             lt;
  logic             last_slice;

  // Slice datapath: one SLICE-wide adder/logic unit fed from the low bits of the operand shifters
  always_comb begin
    a_slice      = a_q[SLICE-1:0];
    b_slice      = b_q[SLICE-1:0];
    is_sub       = (op_q == OP_SUB) || (op_q == OP_SLT);
    legal        = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND) ||
                   (op_q == OP_OR)  || (op_q == OP_SLT);
    b_eff        = is_sub ? ~b_slice : b_slice;
    sum_ext      = {1'b0, a_slice} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
    carry_msb_in = a_slice[SLICE-1] ^ b_eff[SLICE-1] ^ sum_ext[SLICE-1];
    ovf          = carry_msb_in ^ sum_ext[SLICE];
    lt           = sum_ext[SLICE-1] ^ ovf;
    last_slice   = (cnt_q == CW'(NSLICE - 1));
    case (op_q)
      OP_ADD, OP_SUB, OP_SLT: slice_res = sum_ext[SLICE-1:0];
      OP_AND:                 slice_res = a_slice & b_slice;
      OP_OR:                  slice_res = a_slice | b_slice;
      default:                slice_res = '0;
    endcase
  end

  // Next-state logic: accept in IDLE, shift one slice per RUN cycle, publish results on entry to DONE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = srca;
          b_d     = srcb;
          op_d    = alucontrol;
          cnt_d   = '0;
          carry_d = (alucontrol == OP_SUB) || (alucontrol == OP_SLT);
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        acc_d   = {slice_res, acc_q[WIDTH-1:SLICE]};
        carry_d = sum_ext[SLICE];
        cnt_d   = cnt_q + CW'(1);
        if (last_slice) begin
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = DONE;
          if (!legal) begin
            result_d = '0;
          end else if (op_q == OP_SLT) begin
            result_d = {{(WIDTH-1){1'b0}}, lt};
          end else begin
            result_d = acc_d;
          end
          zero_d    = (result_d == '0);
          illegal_d = !legal;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously to the idle/zero-result condition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  // Handshake flags decode straight from the state register so they follow an async reset immediately
  always_comb begin
    ready   = (state_q == IDLE);
    busy    = (state_q == RUN) || (state_q == DONE);
    done    = (state_q == DONE);
    result  = result_q;
    zero    = zero_q;
    illegal = illegal_q;
  end

endmodule
